// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: DEPTH-entry CPU pipeline stage with valid/allow handshake, flush and
// exception squash. Define PIPE_STAGE_PERF_EN to add the stall_cnt/full_cnt counters.
module pipe_stage_fifo #(
   parameter int unsigned       DATA_W    = 64,
   parameter int unsigned       MSG_W     = 16,
   parameter int unsigned       DEPTH     = 2,
   parameter logic [DATA_W-1:0] RESET_VAL = '0,
   parameter bit                HOLD_LAST = 1'b0
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic                         valid_in,
   input  logic [DATA_W-1:0]            data_in,
   input  logic [MSG_W-1:0]             msg_in,
   input  logic                         exc_in,
   output logic                         allow_out,
   input  logic                         ready_go,
   input  logic                         allow_in,
   input  logic                         flush,
   input  logic [DATA_W-1:0]            nop_data,
   output logic                         valid_out,
   output logic [DATA_W-1:0]            data_out,
   output logic [MSG_W-1:0]             msg_out,
   output logic                         exc_out,
   output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]                  stall_cnt,
   output logic [31:0]                  full_cnt
`endif
);

   localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
   localparam int unsigned      PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [MSG_W-1:0]  msg_q  [DEPTH];
   logic [MSG_W-1:0]  msg_d  [DEPTH];
   logic [DEPTH-1:0]  exc_q, exc_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] last_q, last_d;
   logic              not_empty, push, pop;

   // Wrap explicitly so non-power-of-two depths never index past the last entry.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Handshake: allow_out comes from registered occupancy only, breaking the allow chain.
   assign not_empty = (count_q != '0);
   assign allow_out = (count_q != CNT_FULL);
   assign valid_out = not_empty && ready_go;
   assign push      = valid_in && allow_out;
   assign pop       = valid_out && allow_in;
   assign count     = count_q;

   always_comb begin : out_mux
      msg_out  = '0;
      exc_out  = 1'b0;
      data_out = HOLD_LAST ? last_q : nop_data;
      if (not_empty) begin
         data_out = data_q[rptr_q];
         msg_out  = msg_q[rptr_q];
         exc_out  = exc_q[rptr_q];
      end
   end

   always_comb begin : next_state
      data_d  = data_q;
      msg_d   = msg_q;
      exc_d   = exc_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      last_d  = last_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         exc_d   = '0;
      end else begin
         if (push) begin
            data_d[wptr_q] = exc_in ? RESET_VAL : data_in;
            msg_d[wptr_q]  = msg_in;
            exc_d[wptr_q]  = exc_in;
            wptr_d         = ptr_inc(wptr_q);
         end
         if (pop) begin
            last_d = data_q[rptr_q];
            rptr_d = ptr_inc(rptr_q);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge aclk) begin : state_reg
      if (!aresetn) begin
         data_q  <= '{default: RESET_VAL};
         msg_q   <= '{default: '0};
         exc_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         last_q  <= RESET_VAL;
      end else begin
         data_q  <= data_d;
         msg_q   <= msg_d;
         exc_q   <= exc_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         last_q  <= last_d;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, full_cnt_q, full_cnt_d;

   // Saturating event counters, cleared by flush.
   always_comb begin : perf_next
      stall_cnt_d = stall_cnt_q;
      full_cnt_d  = full_cnt_q;
      if (flush) begin
         stall_cnt_d = '0;
         full_cnt_d  = '0;
      end else begin
         if (valid_out && !allow_in && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
         if ((count_q == CNT_FULL) && valid_in && (full_cnt_q != '1))
            full_cnt_d = full_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge aclk) begin : perf_reg
      if (!aresetn) begin
         stall_cnt_q <= '0;
         full_cnt_q  <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         full_cnt_q  <= full_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign full_cnt  = full_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// tb_pipe_stage_fifo: scoreboard bench; instance A is DEPTH=2/HOLD_LAST=0,
// instance B is DEPTH=3/HOLD_LAST=1.
module tb_pipe_stage_fifo;
   localparam int unsigned DW = 32;
   localparam int unsigned MW = 16;
   localparam logic [DW-1:0] RVA = 32'h0BAD_F00D;
   localparam logic [DW-1:0] RVB = 32'h0000_C0DE;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [MW-1:0] m;
      logic          e;
   } ent_t;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   logic          va, ea, rga, aia, fla, aoa, voa, eoa;
   logic [DW-1:0] da, nopa, doa;
   logic [MW-1:0] ma, moa;
   logic [1:0]    cnta;
   logic          vb, eb, rgb, aib, flb, aob, vob, eob;
   logic [DW-1:0] db, nopb, dob;
   logic [MW-1:0] mb, mob;
   logic [1:0]    cntb;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] sta, fca, stb, fcb;
`endif

   ent_t qa[$];
   ent_t qb[$];
   int   n_chk = 0;
   int   n_fail = 0;

   pipe_stage_fifo #(.DATA_W(DW), .MSG_W(MW), .DEPTH(2), .RESET_VAL(RVA), .HOLD_LAST(1'b0)) u_a (
      .aclk(aclk), .aresetn(aresetn), .valid_in(va), .data_in(da), .msg_in(ma), .exc_in(ea),
      .allow_out(aoa), .ready_go(rga), .allow_in(aia), .flush(fla), .nop_data(nopa),
      .valid_out(voa), .data_out(doa), .msg_out(moa), .exc_out(eoa), .count(cnta)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt(sta), .full_cnt(fca)
`endif
   );

   pipe_stage_fifo #(.DATA_W(DW), .MSG_W(MW), .DEPTH(3), .RESET_VAL(RVB), .HOLD_LAST(1'b1)) u_b (
      .aclk(aclk), .aresetn(aresetn), .valid_in(vb), .data_in(db), .msg_in(mb), .exc_in(eb),
      .allow_out(aob), .ready_go(rgb), .allow_in(aib), .flush(flb), .nop_data(nopb),
      .valid_out(vob), .data_out(dob), .msg_out(mob), .exc_out(eob), .count(cntb)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt(stb), .full_cnt(fcb)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic push_a(input logic [DW-1:0] d, input logic [MW-1:0] m, input logic e);
      va = 1'b1; da = d; ma = m; ea = e;
      if (aoa && !fla) qa.push_back(ent_t'{d: (e ? RVA : d), m: m, e: e});
   endtask

   task automatic push_b(input logic [DW-1:0] d, input logic [MW-1:0] m, input logic e);
      vb = 1'b1; db = d; mb = m; eb = e;
      if (aob && !flb) qb.push_back(ent_t'{d: (e ? RVB : d), m: m, e: e});
   endtask

   // Monitors: a pop happens at the next edge whenever valid_out && allow_in without flush.
   always @(negedge aclk) begin : mon_a
      ent_t x;
      if (aresetn && voa && aia && !fla) begin
         if (qa.size() == 0) chk("a_unexpected_pop", 64'(doa), 64'hFFFF_FFFF_FFFF_FFFF);
         else begin
            x = qa.pop_front();
            chk("a_pop_entry", 64'({doa, moa, eoa}), 64'(x));
         end
      end
   end

   always @(negedge aclk) begin : mon_b
      ent_t x;
      if (aresetn && vob && aib && !flb) begin
         if (qb.size() == 0) chk("b_unexpected_pop", 64'(dob), 64'hFFFF_FFFF_FFFF_FFFF);
         else begin
            x = qb.pop_front();
            chk("b_pop_entry", 64'({dob, mob, eob}), 64'(x));
         end
      end
   end

   initial begin : stim
      int sent;
      va = 0; ea = 0; da = '0; ma = '0; rga = 1; aia = 1; fla = 0; nopa = 32'h0000_0013;
      vb = 0; eb = 0; db = '0; mb = '0; rgb = 1; aib = 1; flb = 0; nopb = 32'h0000_0013;

      // Reset state
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      chk("a_rst_count", 64'(cnta), 64'd0);
      chk("a_rst_valid", 64'(voa), 64'd0);
      chk("a_rst_allow", 64'(aoa), 64'd1);
      chk("a_rst_exc", 64'(eoa), 64'd0);
      chk("a_rst_data_nop", 64'(doa), 64'h13);
      chk("b_rst_data_last", 64'(dob), 64'(RVB));
      chk("b_rst_allow", 64'(aob), 64'd1);
      @(posedge aclk); #1;
      aresetn = 1'b1;

      // Single entry: one-cycle latency, then back to nop
      push_a(32'hA5, 16'h0, 1'b0);
      tick();
      va = 0;
      @(negedge aclk);
      chk("a_lat_valid", 64'(voa), 64'd1);
      chk("a_lat_data", 64'(doa), 64'hA5);
      chk("a_lat_count", 64'(cnta), 64'd1);
      tick();
      @(negedge aclk);
      chk("a_empty_count", 64'(cnta), 64'd0);
      chk("a_empty_nop", 64'(doa), 64'h13);
      chk("a_empty_valid", 64'(voa), 64'd0);
      tick();

      // Fill DEPTH=2 with downstream blocked; third push refused
      aia = 0;
      push_a(32'h11, 16'h1, 1'b0); tick();
      push_a(32'h22, 16'h2, 1'b0); tick();
      chk("a_full_allow", 64'(aoa), 64'd0);
      push_a(32'h33, 16'h3, 1'b0); tick();
      va = 0;
      chk("a_full_count", 64'(cnta), 64'd2);
      aia = 1;
      for (int k = 0; k < 10 && qa.size() != 0; k++) tick();
      tick();
      chk("a_drain1_q", 64'(qa.size()), 64'd0);
      chk("a_drain1_count", 64'(cnta), 64'd0);

      // ready_go stall holds the head while pushes fill the stage
      rga = 0;
      push_a(32'h44, 16'h4, 1'b0); tick();
      push_a(32'h55, 16'h5, 1'b0); tick();
      va = 0;
      @(negedge aclk);
      chk("a_stall_valid", 64'(voa), 64'd0);
      chk("a_stall_count", 64'(cnta), 64'd2);
      chk("a_stall_allow", 64'(aoa), 64'd0);
      tick();
      rga = 1;
      for (int k = 0; k < 10 && qa.size() != 0; k++) tick();
      tick();
      chk("a_drain2_q", 64'(qa.size()), 64'd0);

      // Exception squash
      push_a(32'hBEEF, 16'h0042, 1'b1); tick();
      va = 0; ea = 0;
      @(negedge aclk);
      chk("a_exc_valid", 64'(voa), 64'd1);
      chk("a_exc_flag", 64'(eoa), 64'd1);
      chk("a_exc_msg", 64'(moa), 64'h42);
      chk("a_exc_data", 64'(doa), 64'(RVA));
      tick();
      tick();
      chk("a_exc_drained_flag", 64'(eoa), 64'd0);
      chk("a_exc_drained_msg", 64'(moa), 64'd0);

      // Flush at count=2 with a simultaneous valid_in
      aia = 0;
      push_a(32'h56, 16'h6, 1'b0); tick();
      push_a(32'h66, 16'h7, 1'b0); tick();
      chk("a_preflush_count", 64'(cnta), 64'd2);
      fla = 1; push_a(32'h77, 16'h8, 1'b0); tick();
      fla = 0; va = 0; qa.delete();
      @(negedge aclk);
      chk("a_flush_count", 64'(cnta), 64'd0);
      chk("a_flush_valid", 64'(voa), 64'd0);
      chk("a_flush_allow", 64'(aoa), 64'd1);
      tick();
      aia = 1;
      repeat (3) tick();
      chk("a_flush_stays_empty", 64'(cnta), 64'd0);

      // DEPTH=3: 10 entries through pointer wrap with allow_in toggling
      sent = 0;
      for (int cyc = 0; cyc < 100 && sent < 10; cyc++) begin
         aib = (cyc % 3 != 1);
         if (aob) begin
            push_b(32'h100 + 32'(sent), 16'(sent), 1'b0);
            sent++;
         end else begin
            push_b(32'h100 + 32'(sent), 16'(sent), 1'b0);
         end
         tick();
      end
      vb = 0; aib = 1;
      chk("b_wrap_sent", 64'(sent), 64'd10);
      for (int k = 0; k < 20 && qb.size() != 0; k++) tick();
      tick();
      chk("b_wrap_drain_q", 64'(qb.size()), 64'd0);
      chk("b_wrap_count", 64'(cntb), 64'd0);
      chk("b_wrap_hold_last", 64'(dob), 64'h109);

      // HOLD_LAST: last dequeued payload survives empty and flush
      nopb = '0;
      push_b(32'h1234, 16'h9, 1'b0); tick();
      vb = 0;
      tick();
      @(negedge aclk);
      chk("b_hold_count", 64'(cntb), 64'd0);
      chk("b_hold_data", 64'(dob), 64'h1234);
      tick();
      flb = 1; tick(); flb = 0;
      @(negedge aclk);
      chk("b_hold_after_flush", 64'(dob), 64'h1234);
      tick();

      // Flush at count=2 in DEPTH=3: the simultaneous push is dropped
      aib = 0;
      push_b(32'hA1, 16'hA, 1'b0); tick();
      push_b(32'hA2, 16'hB, 1'b0); tick();
      chk("b_preflush_count", 64'(cntb), 64'd2);
      chk("b_preflush_allow", 64'(aob), 64'd1);
      flb = 1; push_b(32'h77, 16'hC, 1'b0); tick();
      flb = 0; vb = 0; qb.delete();
      @(negedge aclk);
      chk("b_flush_count", 64'(cntb), 64'd0);
      chk("b_flush_valid", 64'(vob), 64'd0);
      chk("b_flush_allow", 64'(aob), 64'd1);
      chk("b_flush_data_last", 64'(dob), 64'h1234);
      tick();
      aib = 1;
      repeat (3) tick();
      chk("b_flush_dropped", 64'(cntb), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
